// File: rtl/gpr_pkg.sv
// Shared sizes, instruction-type encodings and small helpers for the
// general-purpose register file and its hazard scoreboard.
package gpr_pkg;

  localparam int GPR_XLEN = 32;
  localparam int GPR_NREG = 32;
  localparam int GPR_AW   = 5;

  // B_type and I_load share an encoding, so these stay plain constants rather than an enum
  localparam logic [2:0] R_TYPE  = 3'b011;
  localparam logic [2:0] S_TYPE  = 3'b010;
  localparam logic [2:0] B_TYPE  = 3'b000;
  localparam logic [2:0] U_TYPE  = 3'b101;
  localparam logic [2:0] I_JUMP  = 3'b110;
  localparam logic [2:0] I_LOGIC = 3'b001;
  localparam logic [2:0] I_LOAD  = 3'b000;

  // True when this cycle's write-back targets ra and ra is not x0
  function automatic logic wb_hit(input logic              en,
                                  input logic [GPR_AW-1:0] wa,
                                  input logic [GPR_AW-1:0] ra);
    return en && (wa == ra) && (ra != '0);
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with RAW/WAW stall
// detection that honours a write-back landing in the same cycle.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NREG = GPR_NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [GPR_AW-1:0] wb_addr,
  input  logic [GPR_AW-1:0] rs1_addr,
  input  logic              rs1_used,
  input  logic [GPR_AW-1:0] rs2_addr,
  input  logic              rs2_used,
  input  logic              rd_reserve_en,
  input  logic [GPR_AW-1:0] rd_reserve_addr,
  input  logic              flush,
  output logic              stall,
  output logic [NREG-1:0]   busy_vec
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            rs1_haz;
  logic            rs2_haz;
  logic            waw_haz;

  always_comb begin
    rs1_haz = rs1_used && (rs1_addr != '0) && busy[rs1_addr]
              && !wb_hit(wb_en, wb_addr, rs1_addr);
    rs2_haz = rs2_used && (rs2_addr != '0) && busy[rs2_addr]
              && !wb_hit(wb_en, wb_addr, rs2_addr);
    waw_haz = rd_reserve_en && (rd_reserve_addr != '0) && busy[rd_reserve_addr]
              && !wb_hit(wb_en, wb_addr, rd_reserve_addr);
    stall   = rs1_haz || rs2_haz || waw_haz;
  end

  // Clear first, then set, so a new producer keeps the bit over a retiring one
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wb_en) busy_nxt[wb_addr] = 1'b0;
      if (rd_reserve_en && !stall && (rd_reserve_addr != '0))
        busy_nxt[rd_reserve_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign busy_vec = busy;

endmodule

// File: rtl/gpr_file.sv
// Integer register file: two combinational read ports with same-cycle
// write-back bypass, one write port, x0 hard-wired to zero.
module gpr_file
  import gpr_pkg::*;
#(
  parameter int XLEN = GPR_XLEN,
  parameter int NREG = GPR_NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_GPR,
  input  logic [XLEN-1:0]   data_in,
  input  logic [GPR_AW-1:0] data_addr,
  input  logic [GPR_AW-1:0] rs1_addr,
  input  logic [GPR_AW-1:0] rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              rd_reserve_en,
  input  logic [GPR_AW-1:0] rd_reserve_addr,
  input  logic              flush,
  output logic              stall,
  output logic [NREG-1:0]   busy_vec
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (en_GPR && (data_addr != '0)) begin
      regs[data_addr] <= data_in;
    end
  end

  always_comb begin
    if (rs1_addr == '0)                            rs1_data = '0;
    else if (wb_hit(en_GPR, data_addr, rs1_addr))  rs1_data = data_in;
    else                                           rs1_data = regs[rs1_addr];

    if (rs2_addr == '0)                            rs2_data = '0;
    else if (wb_hit(en_GPR, data_addr, rs2_addr))  rs2_data = data_in;
    else                                           rs2_data = regs[rs2_addr];
  end

  gpr_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .wb_en           (en_GPR),
    .wb_addr         (data_addr),
    .rs1_addr        (rs1_addr),
    .rs1_used        (rs1_used),
    .rs2_addr        (rs2_addr),
    .rs2_used        (rs2_used),
    .rd_reserve_en   (rd_reserve_en),
    .rd_reserve_addr (rd_reserve_addr),
    .flush           (flush),
    .stall           (stall),
    .busy_vec        (busy_vec)
  );

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: stimulus queues expected values, a negedge
// monitor pops and compares them against the live outputs.
module tb_gpr_file;

  localparam int SEL_RS1   = 0;
  localparam int SEL_RS2   = 1;
  localparam int SEL_STALL = 2;
  localparam int SEL_BUSY  = 3;

  logic        clk;
  logic        rst;
  logic        en_GPR;
  logic [31:0] data_in;
  logic [4:0]  data_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_used;
  logic        rs2_used;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rd_reserve_en;
  logic [4:0]  rd_reserve_addr;
  logic        flush;
  logic        stall;
  logic [31:0] busy_vec;

  string       name_q[$];
  int          sel_q[$];
  logic [31:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  gpr_file dut (
    .clk             (clk),
    .rst             (rst),
    .en_GPR          (en_GPR),
    .data_in         (data_in),
    .data_addr       (data_addr),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rs1_used        (rs1_used),
    .rs2_used        (rs2_used),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .rd_reserve_en   (rd_reserve_en),
    .rd_reserve_addr (rd_reserve_addr),
    .flush           (flush),
    .stall           (stall),
    .busy_vec        (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: at each falling edge, compare everything queued since the rising edge
  initial begin
    forever begin
      @(negedge clk);
      while (name_q.size() > 0) begin
        string       n;
        int          s;
        logic [31:0] e;
        logic [31:0] a;
        n = name_q.pop_front();
        s = sel_q.pop_front();
        e = exp_q.pop_front();
        case (s)
          SEL_RS1:   a = rs1_data;
          SEL_RS2:   a = rs2_data;
          SEL_STALL: a = {31'd0, stall};
          default:   a = busy_vec;
        endcase
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, a, e);
        end
      end
    end
  end

  task automatic chk(input string n, input int s, input logic [31:0] e);
    name_q.push_back(n);
    sel_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_GPR          = 1'b0;
    data_in         = '0;
    data_addr       = '0;
    rs1_addr        = '0;
    rs2_addr        = '0;
    rs1_used        = 1'b0;
    rs2_used        = 1'b0;
    rd_reserve_en   = 1'b0;
    rd_reserve_addr = '0;
    flush           = 1'b0;
  endtask

  task automatic reserve(input logic [4:0] a);
    idle();
    rd_reserve_en   = 1'b1;
    rd_reserve_addr = a;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    en_GPR    = 1'b1;
    data_addr = a;
    data_in   = d;
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // Reset: writes and reservations presented now must not stick
    cyc();
    wb(5'd5, 32'h0000_0011);
    rs1_addr = 5'd5; rs2_addr = 5'd6;
    rd_reserve_en = 1'b1; rd_reserve_addr = 5'd3;
    chk("rst_busy", SEL_BUSY, 32'h0);
    chk("rst_stall", SEL_STALL, 32'h0);
    chk("rst_bypass", SEL_RS1, 32'h0000_0011);
    chk("rst_rs2", SEL_RS2, 32'h0);
    cyc(); idle(); rs1_addr = 5'd5;
    chk("rst_wr_ignored", SEL_RS1, 32'h0);
    chk("rst_resv_ignored", SEL_BUSY, 32'h0);

    // Write/read, accepted on the first edge after reset release
    cyc(); rst = 1'b0; idle(); wb(5'd5, 32'hDEAD_BEEF);
    chk("x0_read", SEL_RS1, 32'h0);
    cyc(); idle(); rs1_addr = 5'd5;
    chk("wr_rd_x5", SEL_RS1, 32'hDEAD_BEEF);

    // Bypass and x0
    cyc(); idle(); wb(5'd7, 32'h1234_5678); rs2_addr = 5'd7; rs1_addr = 5'd5;
    chk("bypass_x7", SEL_RS2, 32'h1234_5678);
    chk("rs1_x5_hold", SEL_RS1, 32'hDEAD_BEEF);
    cyc(); idle(); wb(5'd0, 32'hFFFF_FFFF);
    chk("x0_bypass_rs1", SEL_RS1, 32'h0);
    chk("x0_bypass_rs2", SEL_RS2, 32'h0);
    cyc(); idle(); rs2_addr = 5'd7;
    chk("x0_after_wr", SEL_RS1, 32'h0);
    chk("x7_stored", SEL_RS2, 32'h1234_5678);

    // RAW on x3
    cyc(); reserve(5'd3);
    chk("resv3_nostall", SEL_STALL, 32'h0);
    cyc(); idle(); rs1_addr = 5'd3; rs1_used = 1'b1;
    chk("busy_x3", SEL_BUSY, 32'h0000_0008);
    chk("raw_stall", SEL_STALL, 32'h1);
    cyc(); reserve(5'd4); rs1_addr = 5'd3; rs2_addr = 5'd3; rs2_used = 1'b1;
    chk("raw_stall_rs2", SEL_STALL, 32'h1);
    cyc(); idle(); rs1_addr = 5'd3;
    chk("resv_blocked_by_stall", SEL_BUSY, 32'h0000_0008);
    chk("unused_nostall", SEL_STALL, 32'h0);
    cyc(); idle(); wb(5'd3, 32'h0000_00A5); rs1_addr = 5'd3; rs1_used = 1'b1;
    chk("raw_bypass_nostall", SEL_STALL, 32'h0);
    chk("raw_bypass_data", SEL_RS1, 32'h0000_00A5);
    cyc(); idle(); rs1_addr = 5'd3; rs1_used = 1'b1;
    chk("busy_cleared", SEL_BUSY, 32'h0);
    chk("x3_stored", SEL_RS1, 32'h0000_00A5);

    // x0 never busy, never stalls
    cyc(); reserve(5'd0); rs1_used = 1'b1;
    chk("x0_nostall", SEL_STALL, 32'h0);
    cyc(); idle();
    chk("x0_never_busy", SEL_BUSY, 32'h0);

    // WAW and simultaneous set/clear on x9
    cyc(); reserve(5'd9);
    cyc(); reserve(5'd9);
    chk("waw_stall", SEL_STALL, 32'h1);
    chk("busy_x9", SEL_BUSY, 32'h0000_0200);
    cyc(); reserve(5'd9); wb(5'd9, 32'h0000_0099);
    chk("waw_cleared_nostall", SEL_STALL, 32'h0);
    cyc(); idle(); rs2_addr = 5'd9; rs2_used = 1'b1;
    chk("set_wins", SEL_BUSY, 32'h0000_0200);
    chk("set_wins_stall", SEL_STALL, 32'h1);
    chk("x9_stored", SEL_RS2, 32'h0000_0099);
    cyc(); idle(); wb(5'd9, 32'h0000_009A);
    cyc(); idle();
    chk("x9_cleared", SEL_BUSY, 32'h0);

    // Flush beats reserve, WB still commits
    cyc(); reserve(5'd1);
    cyc(); reserve(5'd2);
    cyc(); reserve(5'd4);
    cyc(); reserve(5'd6); flush = 1'b1; wb(5'd10, 32'h0000_0055);
    chk("busy_124", SEL_BUSY, 32'h0000_0016);
    cyc(); idle(); rs1_addr = 5'd10;
    chk("flush_clears", SEL_BUSY, 32'h0);
    chk("wb_during_flush", SEL_RS1, 32'h0000_0055);

    // Asynchronous reset mid-operation
    cyc(); reserve(5'd1);
    cyc(); reserve(5'd2);
    cyc(); reserve(5'd4);
    cyc(); idle(); rs1_addr = 5'd10; rs2_addr = 5'd2; rs2_used = 1'b1;
    chk("pre_rst_busy", SEL_BUSY, 32'h0000_0016);
    chk("pre_rst_stall", SEL_STALL, 32'h1);
    chk("pre_rst_x10", SEL_RS1, 32'h0000_0055);
    cyc();
    #1 rst = 1'b1;
    chk("async_rst_busy", SEL_BUSY, 32'h0);
    chk("async_rst_x10", SEL_RS1, 32'h0);
    chk("async_rst_stall", SEL_STALL, 32'h0);
    cyc(); rst = 1'b0; idle();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && name_q.size() > 0; i++) @(negedge clk);
    #1;
    if (name_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", name_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpr_file.md
GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 SHALL have parameter XLEN, 32, register data width.
REQ-002 SHALL have parameter NREG, 32, number of architectural registers; address width is log2(NREG) = 5.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port en_GPR, input, 1, write-back enable from the WB stage.
REQ-006 SHALL have port data_in, input, XLEN, write-back data.
REQ-007 SHALL have port data_addr, input, 5, write-back destination register.
REQ-008 SHALL have ports rs1_addr and rs2_addr, input, 5 each, ID-stage source register addresses.
REQ-009 SHALL have ports rs1_used and rs2_used, input, 1 each, high when the ID instruction actually reads that source.
REQ-010 SHALL have ports rs1_data and rs2_data, output, XLEN each, source operands.
REQ-011 SHALL have port rd_reserve_en, input, 1, ID issues an instruction that will write rd_reserve_addr.
REQ-012 SHALL have port rd_reserve_addr, input, 5, destination being reserved.
REQ-013 SHALL have port flush, input, 1, pipeline flush; clears all reservations.
REQ-014 SHALL have port stall, output, 1, ID must hold because of a RAW or WAW hazard.
REQ-015 SHALL have port busy_vec, output, NREG, per-register pending-write bits for debug.

Function
REQ-016 SHALL write data_in to register data_addr at the clock edge when en_GPR=1 and data_addr!=0.
REQ-017 SHALL hold register x0 at constant 0 and ignore writes to it.
REQ-018 SHALL drive rsN_data combinationally, with zero read latency.
REQ-019 SHALL drive rsN_data with data_in when en_GPR=1, data_addr==rsN_addr and rsN_addr!=0 (same-cycle write bypass), else with the stored register value.
REQ-020 SHALL return 0 on rsN_data when rsN_addr==0, regardless of any bypass.
REQ-021 SHALL, in the scoreboard, clear busy[data_addr] at the edge when en_GPR=1.
REQ-022 SHALL, in the scoreboard, set busy[rd_reserve_addr] at the edge when rd_reserve_en=1, stall=0, flush=0 and rd_reserve_addr!=0.
REQ-023 SHALL let the set win when a set and a clear hit the same register in the same cycle, so busy stays 1 for the newer producer.
REQ-024 SHALL assert stall when any of the following holds: (rs1_used & busy[rs1] & not bypassed-this-cycle), (rs2_used & busy[rs2] & not bypassed), or (rd_reserve_en & busy[rd_reserve_addr] & not cleared-this-cycle).
REQ-025 SHALL treat "bypassed" and "cleared" as en_GPR=1 with data_addr equal to the register in question.
REQ-026 SHALL never set or report busy[0] and never stall on address 0.
REQ-027 SHALL, on flush=1, clear every busy bit at the edge; flush has priority over reserve, and WB writes still commit during flush.
REQ-028 SHALL compute stall combinationally from the current busy state and the current inputs; stall is not registered.
REQ-029 SHALL drive busy_vec directly from the busy register.

Reset
REQ-030 SHALL, while rst=1, asynchronously clear all registers x1..x31 to 0 and all busy bits to 0.
REQ-031 SHALL give the following outputs under reset: busy_vec=0, stall=0, and rsN_data=0 unless bypassed.
REQ-032 SHALL ignore writes and reservations presented during reset.
REQ-033 SHALL accept a write or reservation at the first rising edge after rst deasserts.

Structure
REQ-034 SHALL take XLEN, NREG, the address width, and the instruction-type encodings (R_type=011, S_type=010, B_type=000, U_type=101, I_jump=110, I_logic=001, I_load=000) from shared package gpr_pkg.
REQ-035 SHALL implement the busy-bit array and stall logic in one sub-module, gpr_scoreboard; the register array and bypass stay in gpr_file.

Verification
REQ-036 SHALL verify write/read: en_GPR=1, data_addr=5, data_in=0xDEADBEEF for one cycle, then rs1_addr=5 -> rs1_data=0xDEADBEEF.
REQ-037 SHALL verify bypass and x0: in the same cycle as a write of 0x12345678 to x7, rs2_addr=7 -> rs2_data=0x12345678; write 0xFFFFFFFF to x0, then read x0 -> 0.
REQ-038 SHALL verify the RAW stall: reserve x3, next cycle rs1_addr=3 with rs1_used=1 -> stall=1; WB writes x3=0xA5 -> stall=0 that cycle and rs1_data=0xA5.
REQ-039 SHALL verify the simultaneous set/clear: busy[9]=1, same cycle en_GPR to x9 and reserve x9 -> busy_vec[9]=1 after the edge.
REQ-040 SHALL verify flush: reserve x1, x2, x4, then flush=1 with reserve x6 -> busy_vec=0 after the edge.
REQ-041 SHALL verify reset mid-operation: busy_vec=0x16 and x10=0x55, assert rst asynchronously -> busy_vec=0, x10 reads 0 immediately, stall=0.
